// File: rtl/fifo_uart_framer_pkg.sv
// Shared types and constants for the FIFO-to-UART framer.
// Optional checksum trailer: define FIFO_UART_FRAMER_CHECKSUM_EN.
package fifo_uart_framer_pkg;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;

    localparam logic [DATA_W-1:0] SYNC_DEFAULT = 8'hA5;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FILL    = 3'd1;
    localparam logic [2:0] ST_SYNC    = 3'd2;
    localparam logic [2:0] ST_LEN     = 3'd3;
    localparam logic [2:0] ST_PAYLOAD = 3'd4;
    localparam logic [2:0] ST_CHK     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_FILL    = ST_FILL,
        S_SYNC    = ST_SYNC,
        S_LEN     = ST_LEN,
        S_PAYLOAD = ST_PAYLOAD,
        S_CHK     = ST_CHK
    } state_t;

endpackage

// File: rtl/fifo_uart_framer_buf.sv
// Payload holding buffer: MAX_LEN bytes, one write port,
// combinational read port.
module fifo_uart_framer_buf
    import fifo_uart_framer_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int AW      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MAX_LEN];

    // Byte store; reset discards any partially collected frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_uart_framer.sv
// Drains the capture FIFO into SYNC/LEN/payload[/CHK] frames for UART TX.
// Optional checksum trailer: define FIFO_UART_FRAMER_CHECKSUM_EN.
module fifo_uart_framer
    import fifo_uart_framer_pkg::*;
#(
    parameter int                MAX_LEN      = 16,
    parameter int                IDLE_TIMEOUT = 64,
    parameter logic [DATA_W-1:0] SYNC_BYTE    = SYNC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_DATA,
    input  logic              rd_empty,
    output logic              tx_dv,
    output logic [DATA_W-1:0] tx_DATA,
    input  logic              tx_ready,
    output logic              busy
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(IDLE_TIMEOUT);

    localparam logic [TW-1:0]    T_LAST  = TW'(IDLE_TIMEOUT - 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_t            state;
    state_t            state_nx;
    logic [LEN_W-1:0]  count;
    logic [LEN_W-1:0]  idx;
    logic              pending;
    logic [TW-1:0]     tcnt;
    logic [DATA_W-1:0] buf_rdata;
    logic              room;
    logic              full;
    logic              timed_out;
    logic              last_idx;
    logic              buf_we;

`ifdef FIFO_UART_FRAMER_CHECKSUM_EN
    logic [DATA_W-1:0] chk_sum;
`endif

    // Outstanding read counts against capacity so we never over-read.
    assign room = ({1'b0, count} + {{LEN_W{1'b0}}, pending})
                < {1'b0, LEN_MAX};

    assign full      = (count == LEN_MAX);
    assign timed_out = (tcnt == T_LAST) && (count != '0);
    assign last_idx  = (idx == count - 1'b1);
    assign busy      = (state != S_IDLE);
    assign buf_we    = (state == S_FILL) && pending;

    fifo_uart_framer_buf #(
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst),
        .we    (buf_we),
        .waddr (count[AW-1:0]),
        .wdata (rd_DATA),
        .raddr (idx[AW-1:0]),
        .rdata (buf_rdata)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, FIFO read strobe and UART byte presentation.
    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        tx_dv    = 1'b0;
        tx_DATA  = '0;
        unique case (state)
            S_IDLE: begin
                if (!rd_empty) state_nx = S_FILL;
            end
            S_FILL: begin
                rd_en = !rd_empty && room;
                // A read racing the timeout wins.
                if (!pending && !rd_en && (full || timed_out))
                    state_nx = S_SYNC;
            end
            S_SYNC: begin
                tx_dv   = 1'b1;
                tx_DATA = SYNC_BYTE;
                if (tx_ready) state_nx = S_LEN;
            end
            S_LEN: begin
                tx_dv   = 1'b1;
                tx_DATA = count;
                if (tx_ready) state_nx = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                tx_dv   = 1'b1;
                tx_DATA = buf_rdata;
                if (tx_ready && last_idx) begin
`ifdef FIFO_UART_FRAMER_CHECKSUM_EN
                    state_nx = S_CHK;
`else
                    state_nx = S_IDLE;
`endif
                end
            end
`ifdef FIFO_UART_FRAMER_CHECKSUM_EN
            S_CHK: begin
                tx_dv   = 1'b1;
                tx_DATA = chk_sum + count;
                if (tx_ready) state_nx = S_IDLE;
            end
`endif
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Capture bookkeeping, idle timeout and payload index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            idx     <= '0;
            pending <= 1'b0;
            tcnt    <= '0;
`ifdef FIFO_UART_FRAMER_CHECKSUM_EN
            chk_sum <= '0;
`endif
        end else begin
            pending <= rd_en;
            if (state == S_IDLE) begin
                count <= '0;
                idx   <= '0;
                tcnt  <= '0;
`ifdef FIFO_UART_FRAMER_CHECKSUM_EN
                chk_sum <= '0;
`endif
            end
            if (state == S_FILL) begin
                if (pending) begin
                    count <= count + 1'b1;
                    tcnt  <= '0;
`ifdef FIFO_UART_FRAMER_CHECKSUM_EN
                    chk_sum <= chk_sum + rd_DATA;
`endif
                end else if (tcnt != T_LAST) begin
                    tcnt <= tcnt + 1'b1;
                end
            end
            if (state == S_LEN && tx_ready) begin
                idx <= '0;
            end
            if (state == S_PAYLOAD && tx_ready && !last_idx) begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_framer.sv
// Directed bench for fifo_uart_framer: behavioural FIFO source,
// UART byte monitor, per-scenario tasks with inline checks.
module tb_fifo_uart_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd_en;
    logic [7:0] rd_DATA = 8'h00;
    logic       rd_empty;
    logic       tx_dv;
    logic [7:0] tx_DATA;
    logic       tx_ready;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_mem [256];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    int         reads  = 0;

    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];

    fifo_uart_framer dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .rd_DATA  (rd_DATA),
        .rd_empty (rd_empty),
        .tx_dv    (tx_dv),
        .tx_DATA  (tx_DATA),
        .tx_ready (tx_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    assign rd_empty = (rd_ptr == wr_ptr);

    // One-cycle-latency FIFO read side.
    always @(posedge clk) begin
        if (rd_en && !rd_empty) begin
            rd_DATA <= fifo_mem[rd_ptr];
            rd_ptr  <= rd_ptr + 8'd1;
            reads   <= reads + 1;
        end
    end

    // Record every byte that will transfer on the next rising edge.
    always @(negedge clk) begin
        if (tx_dv && tx_ready) rx_q.push_back(tx_DATA);
    end

    task automatic load(input logic [7:0] first, input logic [7:0] step,
                        input int n);
        logic [7:0] b;
        b = first;
        for (int k = 0; k < n; k++) begin
            fifo_mem[wr_ptr] = b;
            wr_ptr = wr_ptr + 8'd1;
            b = b + step;
        end
    endtask

    task automatic add_frame(input logic [7:0] first, input logic [7:0] step,
                             input int n);
        logic [7:0] b;
`ifdef FIFO_UART_FRAMER_CHECKSUM_EN
        logic [7:0] sum;
        sum = 8'(n);
`endif
        b = first;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(n));
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(b);
`ifdef FIFO_UART_FRAMER_CHECKSUM_EN
            sum = sum + b;
`endif
            b = b + step;
        end
`ifdef FIFO_UART_FRAMER_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
    endtask

    task automatic wait_rx(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        tx_ready = 1'b1;
        #2;
        checks++;
        if (rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd_en: got %b expected 0", rd_en);
        end
        checks++;
        if (tx_dv !== 1'b0) begin
            errors++;
            $display("FAIL reset_tx_dv: got %b expected 0", tx_dv);
        end
        checks++;
        if (tx_DATA !== 8'h00) begin
            errors++;
            $display("FAIL reset_tx_data: got %h expected 00", tx_DATA);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0 || reads != 0) begin
            errors++;
            $display("FAIL idle_empty: busy=%b rd_en=%b reads=%0d expected 0 0 0",
                     busy, rd_en, reads);
        end
    endtask

    task automatic test_partial();
        int  base;
        int  n;
        bit  ok;
        logic [7:0] got;
        base = rx_q.size();
        exp_q.delete();
        add_frame(8'h18, 8'h11, 3);
        @(posedge clk);
        #1 load(8'h18, 8'h11, 3);
        n = 0;
        while (!tx_dv && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 70) begin
            errors++;
            $display("FAIL partial_timeout_latency: got %0d cycles expected 70", n);
        end
        wait_rx(base + exp_q.size(), ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL partial_wait: got %0d bytes expected %0d",
                     rx_q.size() - base, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL partial_busy_fall: got %b expected 0", busy);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL partial_byte%0d: got %h expected %h", i, got, exp_q[i]);
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (rx_q.size() != base + exp_q.size()) begin
            errors++;
            $display("FAIL partial_extra: got %0d bytes expected %0d",
                     rx_q.size() - base, exp_q.size());
        end
    endtask

    task automatic test_full();
        int  base;
        int  r0;
        int  n;
        bit  ok;
        logic [7:0] got;
        base = rx_q.size();
        exp_q.delete();
        add_frame(8'h00, 8'h01, 16);
        add_frame(8'h10, 8'h01, 4);
        r0 = reads;
        @(posedge clk);
        #1 load(8'h00, 8'h01, 20);
        n = 0;
        while (!tx_dv && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (reads - r0 != 16) begin
            errors++;
            $display("FAIL full_reads_first_frame: got %0d expected 16", reads - r0);
        end
        wait_rx(base + exp_q.size(), ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL full_wait: got %0d bytes expected %0d",
                     rx_q.size() - base, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL full_busy_fall: got %b expected 0", busy);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL full_byte%0d: got %h expected %h", i, got, exp_q[i]);
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (rx_q.size() != base + exp_q.size() || reads - r0 != 20) begin
            errors++;
            $display("FAIL full_totals: got %0d bytes %0d reads expected %0d bytes 20 reads",
                     rx_q.size() - base, reads - r0, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int  base;
        int  r0;
        int  n;
        bit  ok;
        logic [7:0] got;
        base = rx_q.size();
        exp_q.delete();
        add_frame(8'h41, 8'h01, 3);
        @(posedge clk);
        #1 load(8'h41, 8'h01, 3);
        n = 0;
        while (rx_q.size() < base + 3 && n < 300) begin
            @(posedge clk);
            #1 n++;
        end
        tx_ready = 1'b0;
        r0 = reads;
        load(8'h77, 8'h01, 1);
        add_frame(8'h77, 8'h01, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (tx_dv !== 1'b1 || tx_DATA !== 8'h42) begin
                errors++;
                $display("FAIL stall_hold%0d: got dv=%b data=%h expected dv=1 data=42",
                         c, tx_dv, tx_DATA);
            end
        end
        checks++;
        if (reads != r0 || rx_q.size() != base + 3) begin
            errors++;
            $display("FAIL stall_side_effects: got %0d reads %0d bytes expected 0 reads 3 bytes",
                     reads - r0, rx_q.size() - base);
        end
        @(posedge clk);
        #1 tx_ready = 1'b1;
        wait_rx(base + exp_q.size(), ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_wait: got %0d bytes expected %0d",
                     rx_q.size() - base, exp_q.size());
        end
        @(negedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_byte%0d: got %h expected %h", i, got, exp_q[i]);
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (rx_q.size() != base + exp_q.size()) begin
            errors++;
            $display("FAIL stall_extra: got %0d bytes expected %0d",
                     rx_q.size() - base, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int  base;
        int  n;
        bit  ok;
        logic [7:0] got;
        base = rx_q.size();
        @(posedge clk);
        #1 load(8'h01, 8'h01, 4);
        n = 0;
        while (rx_q.size() < base + 3 && n < 300) begin
            @(posedge clk);
            #1 n++;
        end
        checks++;
        if (busy !== 1'b1 || tx_dv !== 1'b1) begin
            errors++;
            $display("FAIL mid_before_reset: got busy=%b dv=%b expected 1 1", busy, tx_dv);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (rd_en !== 1'b0 || tx_dv !== 1'b0 || tx_DATA !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_reset: got rd_en=%b dv=%b data=%h busy=%b expected 0 0 00 0",
                     rd_en, tx_dv, tx_DATA, busy);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        base = rx_q.size();
        exp_q.delete();
        add_frame(8'h5C, 8'h01, 1);
        #1 load(8'h5C, 8'h01, 1);
        wait_rx(base + exp_q.size(), ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_wait: got %0d bytes expected %0d",
                     rx_q.size() - base, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy_fall: got %b expected 0", busy);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL mid_byte%0d: got %h expected %h", i, got, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_partial();
        test_full();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_framer.md
# fifo_uart_framer

Downstream consumer of the sniffer's BRAM FIFO: drains captured ULPI bytes from the FIFO read port, groups them into length-prefixed frames and hands them byte-by-byte to the UART transmitter. It sits between the FIFO read side and the UART TX, in the FIFO read clock domain. Bursts are collected until MAX_LEN bytes are buffered or the FIFO stays empty for IDLE_TIMEOUT cycles. The frame is then emitted as SYNC, LEN, payload and an optional checksum.

## Interface
- MAX_LEN, 16: maximum payload bytes per frame, range 1..255.
- IDLE_TIMEOUT, 64: cycles with no captured byte that close a partial frame, ≥2.
- SYNC_BYTE, 8'hA5: first byte of every frame.
- clk  in  1  single clock, the FIFO read clock.
- rst  in  1  asynchronous, active-low reset.
- rd_en  out  1  FIFO read strobe.
- rd_DATA  in  8  FIFO read data, valid the cycle after rd_en.
- rd_empty  in  1  FIFO empty flag.
- tx_dv  out  1  byte valid to UART TX.
- tx_DATA  out  8  byte to UART TX.
- tx_ready  in  1  UART TX can accept a byte.
- busy  out  1  high in any state other than IDLE.

## Operation
- State machine states: IDLE, FILL, SYNC, LEN, PAYLOAD, CHK.
- IDLE:
  - Go to FILL when rd_empty=0.
  - Clear byte count, timeout counter and checksum.
- FILL, read strobe:
  - rd_en = (state==FILL) && !rd_empty && (count + pending) < MAX_LEN. This is combinational.
  - pending is 1 when rd_en was high the previous cycle.
- FILL, capture:
  - On the cycle after rd_en, store rd_DATA at buf[count].
  - Increment count and clear the timeout counter.
- FILL, timeout:
  - Every cycle without a capture increments the timeout counter, which saturates.
- FILL, exit (pending=0 is required):
  - Go to SYNC when count==MAX_LEN.
  - Also go to SYNC when the timeout counter reaches IDLE_TIMEOUT-1 and count>0.
  - count is never 0 in FILL once a read has been issued.
- SYNC: tx_DATA=SYNC_BYTE, then go to LEN.
- LEN: tx_DATA=count, then go to PAYLOAD.
- PAYLOAD:
  - tx_DATA=buf[idx], with idx running 0..count-1.
  - After the last byte, go to CHK if checksum is enabled, otherwise go to IDLE.
- CHK: tx_DATA=chk, then go to IDLE.
- Checksum arithmetic:
  - chk = (count + Σ payload) mod 256, 8-bit wrap-around.
  - The sum is accumulated during capture.
- Output handshake:
  - A byte transfers when tx_dv && tx_ready.
  - tx_dv stays high and tx_DATA stays stable until the transfer.
  - The state or index advances only on a transfer.
- No FIFO reads are issued outside FILL. Bytes arriving during transmit wait in the FIFO.
- Reset mid-operation:
  - All state clears immediately and buffered bytes are discarded.
  - Any rd_DATA in flight is ignored.

## Timing
- Reset values:
  - rd_en=0, tx_dv=0, tx_DATA=8'h00, busy=0.
  - State=IDLE and all counters are 0.
- FIFO read latency is 1 cycle. Back-to-back rd_en gives 1 byte/cycle.
- tx_dv rises the cycle after entering SYNC. With tx_ready held high, one byte per cycle.
- Frame length is count+2 bytes, or count+3 with the checksum.
- busy rises the cycle IDLE→FILL and falls the cycle after the last byte transfers.
- Simultaneous rd_empty falling and the timeout threshold in FILL: the read wins, and the timeout counter clears on capture.

## Configuration
- FIFO_UART_FRAMER_CHECKSUM_EN:
  - Defined: the CHK state and the accumulator exist, and a checksum byte ends every frame.
  - Undefined: CHK and the accumulator are removed, and the frame ends after the payload.

## Structure
- Shared header: state encoding localparams, default SYNC_BYTE, and the LEN width of 8.
- One natural sub-module, fifo_uart_framer_buf:
  - MAX_LEN×8 register buffer.
  - Write port (we, waddr, wdata).
  - Combinational read port (raddr → rdata).

## Test plan
- Reset: hold rst=0 → rd_en=0, tx_dv=0, tx_DATA=00, busy=0. Release with the FIFO empty → stays in IDLE.
- Partial frame: FIFO holds 18, 29, 3A, then empty for 64 cycles → UART sees A5 03 18 29 3A 7E.
- Full frame: 20 bytes 00..13 available at once, MAX_LEN=16:
  - First frame A5 10 00..0F, chk = (0x10 + 0x78) mod 256 = 0x88.
  - After timeout, second frame A5 04 10 11 12 13, chk = 0x4A.
- Backpressure: tx_ready low for 5 cycles at PAYLOAD index 1 → tx_DATA stable throughout, no loss or duplication, 0 FIFO reads during transmit.
- Reset mid-PAYLOAD: assert rst → outputs return to reset values asynchronously. The next 1-byte frame, 5C, is emitted as A5 01 5C 5D.
- Checksum compiled out, 3-byte case → A5 03 18 29 3A, and busy falls after 3A.
